lemming_dig_arbiter: RTL and testbench

- Shares a limited pool of dig tools among N_LEM lemming controllers.
- Each lemming controller takes one dig input and reports digging/splat status.
- This block:
  - takes player dig requests per lemming;
  - issues single-cycle dig pulses round-robin while tools remain;
  - tracks which lemming holds a tool;
  - reclaims tools when digging ends, the lemming dies, or a grant is ignored.
- Sits between the player-input decoder and the array of lemming controllers.

---
 rtl/lemming_pkg.sv | 27 ++
 rtl/lemming_dig_slot.sv | 109 ++++++++++
 rtl/lemming_dig_arbiter.sv | 111 +++++++++++
 tb/tb_lemming_dig_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lemming_pkg.sv
// Shared definitions for the lemming dig-tool arbiter.
//   slot_state_t      : per-slot lifecycle (IDLE, GRANTED, HELD, DEAD)
//   *_DEF localparams : default pool/slot sizing used by the top
//   popcount()        : counts set bits of a vector zero-extended to 32 bits
package lemming_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    HELD    = 2'd2,
    DEAD    = 2'd3
  } slot_state_t;

  localparam int N_LEM_DEF         = 4;
  localparam int N_TOOLS_DEF       = 2;
  localparam int GRANT_TIMEOUT_DEF = 4;

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int b = 0; b < 32; b++) begin
      if (v[b]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/lemming_dig_slot.sv
// One lemming slot: lifecycle FSM plus the grant timeout counter.
// Ports:
//   i_clk, i_areset : clock, asynchronous active-high reset
//   i_dig_req       : player request for this lemming (level)
//   i_digging       : lemming controller reports digging
//   i_splat         : lemming is dead (sticky in controller)
//   i_sel           : arbiter picked this slot this cycle
//   o_eligible      : slot may be picked this cycle (combinational)
//   o_release       : slot gives its tool back at the coming edge (combinational)
//   o_holder        : slot owns a tool (GRANTED or HELD), registered
//   o_dead          : slot is DEAD, registered
module lemming_dig_slot
  import lemming_pkg::*;
#(
  parameter int GRANT_TIMEOUT = GRANT_TIMEOUT_DEF
) (
  input  logic i_clk,
  input  logic i_areset,
  input  logic i_dig_req,
  input  logic i_digging,
  input  logic i_splat,
  input  logic i_sel,
  output logic o_eligible,
  output logic o_release,
  output logic o_holder,
  output logic o_dead
);

  localparam int CNT_W = $clog2(GRANT_TIMEOUT + 1);

  slot_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_holder;
  logic             r_dead;

  // A splatted lemming is never eligible even in the cycle before it
  // reaches DEAD, so the arbiter cannot hand it a tool.
  assign o_eligible = (r_state == IDLE) && i_dig_req && !i_splat;

  always_comb begin
    o_release = 1'b0;
    case (r_state)
      GRANTED: o_release = i_splat || (!i_digging && (r_cnt == CNT_W'(1)));
      HELD:    o_release = i_splat || !i_digging;
      default: o_release = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_holder <= 1'b0;
      r_dead   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // digging while IDLE is an unsolicited dig: deliberately ignored
          if (i_splat) begin
            r_state <= DEAD;
            r_dead  <= 1'b1;
          end else if (i_sel) begin
            r_state  <= GRANTED;
            r_cnt    <= CNT_W'(GRANT_TIMEOUT);
            r_holder <= 1'b1;
          end
        end
        GRANTED: begin
          if (i_splat) begin
            r_state  <= DEAD;
            r_cnt    <= '0;
            r_holder <= 1'b0;
            r_dead   <= 1'b1;
          end else if (i_digging) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_W'(1)) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_holder <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        HELD: begin
          if (i_splat) begin
            r_state  <= DEAD;
            r_holder <= 1'b0;
            r_dead   <= 1'b1;
          end else if (!i_digging) begin
            r_state  <= IDLE;
            r_holder <= 1'b0;
          end
        end
        DEAD: begin
          r_state <= DEAD;
        end
        default: begin
          r_state  <= IDLE;
          r_holder <= 1'b0;
        end
      endcase
    end
  end

  assign o_holder = r_holder;
  assign o_dead   = r_dead;

endmodule

// File: rtl/lemming_dig_arbiter.sv
// Round-robin arbiter sharing N_TOOLS dig tools among N_LEM lemmings.
// Ports:
//   clk, areset : clock, asynchronous active-high reset
//   dig_req     : per-lemming player request (level)
//   digging     : per-lemming digging status
//   splat       : per-lemming death flag
//   dig_grant   : registered one-cycle dig pulse, at most one bit set
//   tools_free  : registered count of unallocated tools
//   holder      : slots currently owning a tool
//   dead_mask   : slots in DEAD
module lemming_dig_arbiter
  import lemming_pkg::*;
#(
  parameter int N_LEM         = N_LEM_DEF,
  parameter int N_TOOLS       = N_TOOLS_DEF,
  parameter int GRANT_TIMEOUT = GRANT_TIMEOUT_DEF
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic [N_LEM-1:0]             dig_req,
  input  logic [N_LEM-1:0]             digging,
  input  logic [N_LEM-1:0]             splat,
  output logic [N_LEM-1:0]             dig_grant,
  output logic [$clog2(N_TOOLS+1)-1:0] tools_free,
  output logic [N_LEM-1:0]             holder,
  output logic [N_LEM-1:0]             dead_mask
);

  localparam int TF_W  = $clog2(N_TOOLS + 1);
  localparam int PTR_W = (N_LEM > 1) ? $clog2(N_LEM) : 1;

  logic [N_LEM-1:0] w_eligible;
  logic [N_LEM-1:0] w_release;
  logic [N_LEM-1:0] w_holder;
  logic [N_LEM-1:0] w_dead;
  logic [N_LEM-1:0] w_sel;
  logic             w_found;
  logic             w_grant_now;
  logic [PTR_W-1:0] w_win;
  logic [PTR_W-1:0] w_idx;
  int               w_nrel;
  int               w_nheld;

  logic [N_LEM-1:0] r_grant;
  logic [TF_W-1:0]  r_tools_free;
  logic [PTR_W-1:0] r_rr;

  for (genvar i = 0; i < N_LEM; i++) begin : g_slot
    lemming_dig_slot #(
      .GRANT_TIMEOUT(GRANT_TIMEOUT)
    ) u_slot (
      .i_clk      (clk),
      .i_areset   (areset),
      .i_dig_req  (dig_req[i]),
      .i_digging  (digging[i]),
      .i_splat    (splat[i]),
      .i_sel      (w_sel[i]),
      .o_eligible (w_eligible[i]),
      .o_release  (w_release[i]),
      .o_holder   (w_holder[i]),
      .o_dead     (w_dead[i])
    );
  end

  // First eligible slot at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_LEM; k++) begin
      w_idx = PTR_W'((int'(r_rr) + k) % N_LEM);
      if (!w_found && w_eligible[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Decision uses the registered count, so a tool released this cycle is
  // only grantable next cycle; requests seen with an empty pool are dropped.
  assign w_grant_now = w_found && (r_tools_free != '0);
  assign w_sel       = w_grant_now ? (N_LEM'(1) << w_win) : '0;
  assign w_nrel      = popcount(32'(w_release));
  assign w_nheld     = popcount(32'(w_holder));

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_grant      <= '0;
      r_tools_free <= TF_W'(N_TOOLS);
      r_rr         <= '0;
    end else begin
      r_grant      <= w_sel;
      r_tools_free <= TF_W'(int'(r_tools_free) - (w_grant_now ? 1 : 0) + w_nrel);
      if (w_grant_now) begin
        r_rr <= PTR_W'((int'(w_win) + 1) % N_LEM);
      end
    end
  end

  // Every tool is either in the pool or owned by exactly one slot.
  a_pool_conserved: assert property (
    @(posedge clk) disable iff (areset)
      (int'(r_tools_free) + w_nheld) == N_TOOLS
  );

  assign dig_grant  = r_grant;
  assign tools_free = r_tools_free;
  assign holder     = w_holder;
  assign dead_mask  = w_dead;

endmodule

// File: tb/tb_lemming_dig_arbiter.sv
module tb_lemming_dig_arbiter;

  localparam int NL = 4;
  localparam int NT = 2;
  localparam int GT = 4;

  logic          clk = 1'b0;
  logic          areset;
  logic [NL-1:0] dig_req;
  logic [NL-1:0] digging;
  logic [NL-1:0] splat;
  logic [NL-1:0] dig_grant;
  logic [1:0]    tools_free;
  logic [NL-1:0] holder;
  logic [NL-1:0] dead_mask;

  always #5 clk = ~clk;

  lemming_dig_arbiter #(
    .N_LEM(NL), .N_TOOLS(NT), .GRANT_TIMEOUT(GT)
  ) dut (
    .clk        (clk),
    .areset     (areset),
    .dig_req    (dig_req),
    .digging    (digging),
    .splat      (splat),
    .dig_grant  (dig_grant),
    .tools_free (tools_free),
    .holder     (holder),
    .dead_mask  (dead_mask)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [3:0] h,
                           input logic [1:0] f, input logic [3:0] d);
    check({tag, " dig_grant"},  32'(dig_grant),  32'(g));
    check({tag, " holder"},     32'(holder),     32'(h));
    check({tag, " tools_free"}, 32'(tools_free), 32'(f));
    check({tag, " dead_mask"},  32'(dead_mask),  32'(d));
  endtask

  // Leaves the DUT out of reset at posedge+2 with all inputs low.
  task automatic do_reset();
    areset  = 1'b1;
    dig_req = '0;
    digging = '0;
    splat   = '0;
    @(posedge clk);
    #1 areset = 1'b0;
    #1 check_all("reset", 4'b0000, 4'b0000, 2'd2, 4'b0000);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         rst;
    logic [3:0] req, dig, spl;
    logic [3:0] egr, ehold, edead;
    logic [1:0] efree;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, logic [3:0] req, logic [3:0] dig, logic [3:0] spl,
                              logic [3:0] egr, logic [3:0] ehold, logic [1:0] efree,
                              logic [3:0] edead);
    vec_t v;
    v.rst = rst; v.req = req; v.dig = dig; v.spl = spl;
    v.egr = egr; v.ehold = ehold; v.efree = efree; v.edead = edead;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Each lemming either owns a tool or not; an owned tool is either
  // confirmed by digging or waiting with an age since its grant pulse.
  bit         m_tool [NL];
  bit         m_dug  [NL];
  bit         m_dead [NL];
  int         m_age  [NL];
  int         m_free;
  int         m_rr;
  logic [3:0] m_grant;

  function automatic void model_reset();
    for (int i = 0; i < NL; i++) begin
      m_tool[i] = 0; m_dug[i] = 0; m_dead[i] = 0; m_age[i] = 0;
    end
    m_free = NT; m_rr = 0; m_grant = '0;
  endfunction

  function automatic void model_step();
    int win;
    int nrel;
    bit rel;
    win = -1;
    nrel = 0;
    if (m_free > 0) begin
      for (int k = 0; k < NL; k++) begin
        int i;
        i = (m_rr + k) % NL;
        if (win < 0 && dig_req[i] && !m_tool[i] && !m_dead[i] && !splat[i]) win = i;
      end
    end
    for (int i = 0; i < NL; i++) begin
      rel = 0;
      if (!m_dead[i]) begin
        if (splat[i]) begin
          rel = m_tool[i];
          m_dead[i] = 1;
          m_tool[i] = 0;
          m_dug[i]  = 0;
        end else if (m_tool[i]) begin
          if (m_dug[i]) begin
            if (!digging[i]) rel = 1;
          end else if (digging[i]) begin
            m_dug[i] = 1;
          end else if (m_age[i] == GT - 1) begin
            rel = 1;
          end else begin
            m_age[i]++;
          end
          if (rel) begin
            m_tool[i] = 0;
            m_dug[i]  = 0;
          end
        end
      end
      if (rel) nrel++;
    end
    m_grant = '0;
    if (win >= 0) begin
      m_tool[win] = 1; m_dug[win] = 0; m_age[win] = 0;
      m_grant[win] = 1'b1;
      m_rr = (win + 1) % NL;
      m_free--;
    end
    m_free += nrel;
  endfunction

  function automatic logic [3:0] pack_bits(input bit b [NL]);
    logic [3:0] v;
    for (int i = 0; i < NL; i++) v[i] = b[i];
    return v;
  endfunction

  initial begin
    // single request, dig, release
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0001, 0, 4'b0000, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0001, 0, 4'b0000, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 2, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 2, 0));
    // all request, pool drains, round-robin resumes at slot 2
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 4'b0001, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 4'b0010, 4'b0011, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0001, 0, 4'b0000, 4'b0011, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0011, 0, 4'b0000, 4'b0011, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0011, 0, 4'b0000, 4'b0011, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0010, 0, 4'b0000, 4'b0010, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0010, 0, 4'b0100, 4'b0110, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0010, 0, 4'b0000, 4'b0110, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b0110, 0, 4'b0000, 4'b0110, 0, 0));
    // grant ignored: tool reclaimed 4 cycles after the pulse
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0100, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0100, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0100, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0100, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 2, 0));
    // two holders splat together; dead slot never granted again
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1, 4'b0000));
    tbl.push_back(mk(0, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 4'b0011, 0, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0011, 0, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0011, 0, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 2, 4'b0011));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 2, 4'b0011));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 2, 4'b0011));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 4'b0011, 4'b0000, 4'b0000, 2, 4'b0011));
    // release coincides with pending request on slot 3
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 4'b0011, 4'b0000, 0, 4'b0001, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b0011, 4'b0000, 0, 4'b0010, 4'b0011, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b0001, 0, 4'b0000, 4'b0011, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b0011, 0, 4'b0000, 4'b0011, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b0010, 0, 4'b0000, 4'b0010, 1, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b0010, 0, 4'b1000, 4'b1010, 0, 0));
    // digging with no grant is ignored
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b1111, 0, 4'b0000, 4'b0000, 2, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 2, 0));

    foreach (tbl[n]) begin
      if (tbl[n].rst) begin
        do_reset();
      end else begin
        dig_req = tbl[n].req;
        digging = tbl[n].dig;
        splat   = tbl[n].spl;
        @(posedge clk);
        #1 check_all($sformatf("row%0d", n), tbl[n].egr, tbl[n].ehold, tbl[n].efree, tbl[n].edead);
      end
    end

    // areset asserted while a grant pulse is live and two tools are out
    do_reset();
    dig_req = 4'b0011;
    @(posedge clk);
    #1 check("midrst first grant", 32'(dig_grant), 32'h1);
    @(posedge clk);
    #1 check_all("midrst pre", 4'b0010, 4'b0011, 2'd0, 4'b0000);
    areset = 1'b1;
    #1 check_all("midrst async", 4'b0000, 4'b0000, 2'd2, 4'b0000);
    @(posedge clk);
    #1 areset = 1'b0;
    dig_req = 4'b1111;
    @(posedge clk);
    #1 check_all("midrst after", 4'b0001, 4'b0001, 2'd1, 4'b0000);

    // randomized traffic against the reference model
    begin
      logic [3:0] spl;
      spl = '0;
      for (int cyc = 0; cyc < 800; cyc++) begin
        int bias;
        if (cyc % 160 == 0) begin
          do_reset();
          model_reset();
          spl = '0;
        end
        bias = ((cyc / 40) % 2 == 1) ? 3 : 1;
        if ($urandom_range(0, 60) == 0) spl[$urandom_range(0, NL - 1)] = 1'b1;
        dig_req = 4'($urandom);
        for (int i = 0; i < NL; i++) digging[i] = ($urandom_range(0, 3) < bias);
        splat = spl;
        @(posedge clk);
        model_step();
        #1;
        check($sformatf("rnd%0d dig_grant", cyc),  32'(dig_grant),  32'(m_grant));
        check($sformatf("rnd%0d holder", cyc),     32'(holder),     32'(pack_bits(m_tool)));
        check($sformatf("rnd%0d tools_free", cyc), 32'(tools_free), 32'(m_free));
        check($sformatf("rnd%0d dead_mask", cyc),  32'(dead_mask),  32'(pack_bits(m_dead)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
